ex_muldiv_unit: RTL

Multi-cycle RV32M/RV64M multiply/divide unit attached to the execute stage; takes forwarded operands and an M-extension op from EX, stalls the pipeline through the hazard unit while busy, and returns one XLEN result per accepted request. It generalises the EX stage's single-cycle ALU path:

- XLEN and multiplier depth are parameters.
- Divides iterate one bit per cycle.
- In-flight work aborts on pipeline flush.

---
 rtl/ex_muldiv_unit_pkg.sv | 60 ++++++
 rtl/ex_muldiv_unit_divider.sv | 81 ++++++++
 rtl/ex_muldiv_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types for the execute-stage M-extension unit: op encoding, FSM states
// and the control-word field that steers EX results through the mul/div path.
package ex_muldiv_unit_pkg;

  // funct3 encoding of the RV32M/RV64M ops
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_t;

  typedef enum logic [1:0] {
    ALUSRC_REG,
    ALUSRC_IMM,
    ALUSRC_PC,
    ALUSRC_MULDIV
  } alusrc_t;

  typedef struct packed {
    alusrc_t    alusrc;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    muldiv_op_t muldiv_op;
  } control_signal_t;

  function automatic logic is_div_op(input muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem_op(input muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_div(input muldiv_op_t op);
    return op[2] & ~op[0];
  endfunction

  function automatic logic mul_a_signed(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  function automatic logic mul_b_signed(input muldiv_op_t op);
    return op == OP_MULH;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_divider.sv
// Iterative restoring divider on unsigned magnitudes; the first quotient bit is
// resolved on the start edge so results are ready XLEN cycles after start.
module muldiv_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            done_o
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN);

  logic [XLEN-1:0]  quot_q, quot_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] step_rem, step_quot, step_dvs;
  logic [XLEN-1:0] next_rem, next_quot;
  logic [XLEN:0]   trial;

  // One restoring step: shift the next dividend bit into the partial remainder
  always_comb begin
    step_rem  = start_i ? '0 : rem_q;
    step_quot = start_i ? dividend_i : quot_q;
    step_dvs  = start_i ? divisor_i : dvs_q;
    trial     = {step_rem, step_quot[XLEN-1]} - {1'b0, step_dvs};
    if (!trial[XLEN]) begin
      next_rem  = trial[XLEN-1:0];
      next_quot = {step_quot[XLEN-2:0], 1'b1};
    end else begin
      next_rem  = {step_rem[XLEN-2:0], step_quot[XLEN-1]};
      next_quot = {step_quot[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      quot_d = next_quot;
      rem_d  = next_rem;
      dvs_d  = divisor_i;
      cnt_d  = CNT_W'(1);
    end else if (cnt_q != '0 && cnt_q != LAST) begin
      quot_d = next_quot;
      rem_d  = next_rem;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign done_o      = (cnt_q == LAST);

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle M-extension unit beside the EX ALU: pipelined multiplier, iterative
// divider, pipeline stall while busy, and abort on flush.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            start,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  input  logic            hold,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  generate
    if (MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_bad_stages
      $error("ex_muldiv_unit: MUL_STAGES must be in 1..4");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("ex_muldiv_unit: XLEN must be 32 or 64");
    end
  endgenerate

  localparam int CNT_W = $clog2(XLEN + 1);
  // The top two bits of the (2*XLEN+2)-bit signed product are never returned,
  // so the pipeline only carries the low 2*XLEN bits.
  localparam int PW    = 2 * XLEN;
  localparam int NPIPE = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [PW-1:0]    mul_pipe_q [NPIPE];
  logic [PW-1:0]    mul_pipe_d [NPIPE];

  muldiv_op_t      req_op_t;
  logic            accept;
  logic [XLEN:0]   a_ext, b_ext;
  logic [PW-1:0]   prod_comb, mul_tail;
  logic            a_neg_in, b_neg_in, div_by_zero, div_ovf, div_start, div_done;
  logic [XLEN-1:0] a_mag, b_mag, div_quot, div_rem, quot_fix, rem_fix;

  function automatic logic [XLEN-1:0] mul_pick(input muldiv_op_t op, input logic [PW-1:0] p);
    return (op == OP_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
  endfunction

  assign req_op_t = muldiv_op_t'(req_op);
  assign accept   = (state_q == ST_IDLE) && req_valid && !flush;

  always_comb begin
    a_ext     = {mul_a_signed(req_op_t) & in_a[XLEN-1], in_a};
    b_ext     = {mul_b_signed(req_op_t) & in_b[XLEN-1], in_b};
    prod_comb = {{(XLEN-1){a_ext[XLEN]}}, a_ext} * {{(XLEN-1){b_ext[XLEN]}}, b_ext};
  end

  always_comb begin
    a_neg_in    = is_signed_div(req_op_t) & in_a[XLEN-1];
    b_neg_in    = is_signed_div(req_op_t) & in_b[XLEN-1];
    a_mag       = a_neg_in ? -in_a : in_a;
    b_mag       = b_neg_in ? -in_b : in_b;
    div_by_zero = (in_b == '0);
    div_ovf     = is_signed_div(req_op_t) && (in_a == MOST_NEG) && (in_b == '1);
    div_start   = accept && is_div_op(req_op_t) && !div_by_zero && !div_ovf;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPIPE; gi++) begin : g_mul_pipe
      if (gi == 0) begin : g_head
        assign mul_pipe_d[gi] = (accept && !is_div_op(req_op_t)) ? prod_comb : mul_pipe_q[gi];
      end else begin : g_body
        assign mul_pipe_d[gi] = mul_pipe_q[gi-1];
      end
    end
    if (MUL_STAGES == 1) begin : g_tail_comb
      assign mul_tail = prod_comb;
    end else begin : g_tail_pipe
      assign mul_tail = mul_pipe_q[MUL_STAGES-2];
    end
  endgenerate

  muldiv_divider #(.XLEN(XLEN)) u_divider (
    .clk        (clk),
    .rst_n      (start),
    .start_i    (div_start),
    .clear_i    (flush),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quotient_o (div_quot),
    .remainder_o(div_rem),
    .done_o     (div_done)
  );

  assign quot_fix = (a_neg_q ^ b_neg_q) ? -div_quot : div_quot;
  assign rem_fix  = a_neg_q ? -div_rem : div_rem;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    done_d   = done_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = req_op_t;
          a_neg_d = a_neg_in;
          b_neg_d = b_neg_in;
          if (!is_div_op(req_op_t)) begin
            if (MUL_STAGES == 1) begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              result_d = mul_pick(req_op_t, prod_comb);
            end else begin
              state_d = ST_MUL;
              cnt_d   = CNT_W'(MUL_STAGES - 2);
            end
          end else if (div_by_zero) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = is_rem_op(req_op_t) ? in_a : '1;
          end else if (div_ovf) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = is_rem_op(req_op_t) ? '0 : in_a;
          end else begin
            state_d = ST_DIV;
            cnt_d   = CNT_W'(XLEN - 1);
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = mul_pick(op_q, mul_tail);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (cnt_q == '0 && div_done) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = is_rem_op(op_q) ? rem_fix : quot_fix;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        // No acceptance here: the retiring instruction still drives req_valid
        if (!hold) begin
          state_d  = ST_IDLE;
          done_d   = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      for (int i = 0; i < NPIPE; i++) mul_pipe_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      done_q   <= done_d;
      result_q <= result_d;
      for (int i = 0; i < NPIPE; i++) mul_pipe_q[i] <= mul_pipe_d[i];
    end
  end

  assign stall_o  = start & ~flush &
                    (((state_q == ST_IDLE) & req_valid) | (state_q == ST_MUL) | (state_q == ST_DIV));
  assign done_o   = done_q & ~flush;
  assign result_o = done_o ? result_q : '0;

endmodule
